// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a one-entry decode slot,
// redirect/exception steering and misaligned-fetch fault generation.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_pc,
  output logic [31:0] d_pcplus4,
  output logic [31:0] d_instr,
  output logic        d_adel
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, dpc_q, dpc_d, dins_q, dins_d;
  logic        disc_q, disc_d, adel_q, adel_d;
  logic        redir, aligned;
  logic [31:0] target;
  assign redir   = exc_valid | redir_valid;
  assign target  = exc_valid ? exc_pc : redir_pc;
  assign aligned = pc_q[1:0] == 2'b00;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      disc_q  <= 1'b0;
      dpc_q   <= '0;
      dins_q  <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      disc_q  <= disc_d;
      dpc_q   <= dpc_d;
      dins_q  <= dins_d;
      adel_q  <= adel_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    dpc_d   = dpc_q;
    dins_d  = dins_q;
    adel_d  = adel_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir) pc_d = target;
      end
      REQ: begin
        if (redir) begin
          pc_d = target;
          // an accepted request still returns data, which must be thrown away
          if (aligned && inst_addr_ok) begin
            state_d = WAIT;
            disc_d  = 1'b1;
          end
        end else if (!aligned) begin
          state_d = FULL;
          dpc_d   = pc_q;
          dins_d  = '0;
          adel_d  = 1'b1;
        end else if (inst_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (inst_data_ok) begin
          state_d = REQ;
          disc_d  = 1'b0;
          if (redir) pc_d = target;
          else if (!disc_q) begin
            state_d = FULL;
            dpc_d   = pc_q;
            dins_d  = inst_rdata;
            adel_d  = 1'b0;
            pc_d    = pc_q + 32'd4;
          end
        end else if (redir) begin
          pc_d   = target;
          disc_d = 1'b1;
        end
      end
      FULL: begin
        if (redir) begin
          pc_d    = target;
          state_d = REQ;
        end else if (d_ready) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    inst_req  = (state_q == REQ) && aligned;
    inst_addr = pc_q;
    d_valid   = state_q == FULL;
    d_pc      = dpc_q;
    d_pcplus4 = dpc_q + 32'd4;
    d_instr   = dins_q;
    d_adel    = adel_q;
  end
endmodule
